// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-side memory port.
// Holds func3 size encodings, MMIO window constants, FSM state encodings and
// the alignment check used by the request decoder.
package riscv_mem_pkg;

   // func3 load/store size encodings (stores use only [1:0])
   localparam logic [2:0] SizeLb  = 3'b000;
   localparam logic [2:0] SizeLh  = 3'b001;
   localparam logic [2:0] SizeLw  = 3'b010;
   localparam logic [2:0] SizeLbu = 3'b100;
   localparam logic [2:0] SizeLhu = 3'b101;

   // MMIO window: req_addr[31:28] tag and offsets within the window
   localparam logic [3:0]  MmioTag        = 4'h8;
   localparam logic [27:0] MmioCycleOff   = 28'h10;
   localparam logic [27:0] MmioInstretOff = 28'h14;
   localparam logic [27:0] MmioClearOff   = 28'h18;

   // FSM state encodings
   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StResp = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   // Halves need an even offset, words need offset 0; bytes are always aligned.
   function automatic logic is_misaligned(logic [2:0] size, logic [1:0] off);
      logic mis;
      case (size[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Bus between dmem_port and the multi-cycle data memory.
//   master: request side (valid/mask/addr/wdata out, ready/resp in)
//   slave : memory side
interface dmem_port_if #(
   parameter int unsigned ADDR_W = 14
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [3:0]        mem_we_mask;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_resp_valid;
   logic [31:0]       mem_resp_data;

   modport master (
      output mem_req_valid, mem_we_mask, mem_addr, mem_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport slave (
      input  mem_req_valid, mem_we_mask, mem_addr, mem_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port (purely combinational).
//   size_i/off_i : func3 size and byte offset of the access
//   wdata_i      : right-aligned store data
//   rword_i      : raw word read back (memory or MMIO)
//   mask_o       : byte write mask for a store
//   wdata_o      : store data replicated across lanes
//   rdata_o      : selected and sign/zero-extended load result
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  mask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign shifted  = rword_i >> {off_i, 3'b000};
   assign sel_byte = shifted[7:0];
   assign sel_half = off_i[1] ? rword_i[31:16] : rword_i[15:0];

   always_comb begin
      mask_o  = 4'b1111;
      wdata_o = wdata_i;
      case (size_i[1:0])
         2'b00: begin
            mask_o  = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            mask_o  = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      rdata_o = rword_i;
      case (size_i)
         SizeLb:  rdata_o = {{24{sel_byte[7]}}, sel_byte};
         SizeLh:  rdata_o = {{16{sel_half[15]}}, sel_half};
         SizeLbu: rdata_o = {24'b0, sel_byte};
         SizeLhu: rdata_o = {16'b0, sel_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_port.sv
// Data-side load/store responder for the pipeline.
// Decodes the request, runs a 4-state handshake with the data memory, extends
// load data, and serves an MMIO window with free-running cycle/instret counters.
//   clk, reset           : clock, asynchronous active-high reset
//   req_*                : pipeline load/store request
//   retire               : instruction retired (instret increment)
//   stall                : pipeline hold while a memory access is in flight
//   rdata/rdata_valid    : extended load result and its one-cycle strobe
//   misalign             : one-cycle strobe for a rejected misaligned request
//   mem                  : memory bus (master side)
module dmem_port
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = 14,
   parameter logic [3:0]  MMIO_TAG = MmioTag
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        retire,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        misalign,
   dmem_port_if.master mem
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [1:0]        off_q;
   logic              we_q;
   logic [3:0]        mask_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              rdata_valid_q;
   logic              misalign_q;
   logic [31:0]       cycle_q;
   logic [31:0]       instret_q;

   logic        is_idle, live_mis, is_mmio, mem_start, mmio_acc, clr;
   logic [27:0] mmio_off;
   logic [31:0] mmio_word;
   logic [2:0]  al_size;
   logic [1:0]  al_off;
   logic [31:0] al_rword, al_rdata, al_wdata;
   logic [3:0]  al_mask;

   assign is_idle   = (state_q == StIdle);
   assign live_mis  = is_misaligned(req_size, req_addr[1:0]);
   assign is_mmio   = (req_addr[31:28] == MMIO_TAG);
   assign mmio_off  = req_addr[27:0];
   assign mem_start = is_idle & req_valid & ~live_mis & ~is_mmio;
   assign mmio_acc  = is_idle & req_valid & ~live_mis & is_mmio;
   assign clr       = mmio_acc & req_we & (mmio_off == MmioClearOff);

   // MMIO reads are word-granular; the aligner picks the byte/half afterwards
   always_comb begin
      mmio_word = 32'b0;
      if (mmio_off[27:2] == MmioCycleOff[27:2]) begin
         mmio_word = cycle_q;
      end else if (mmio_off[27:2] == MmioInstretOff[27:2]) begin
         mmio_word = instret_q;
      end
   end

   // Aligner sees the live request in IDLE (latch/MMIO) and the held fields otherwise
   assign al_size  = is_idle ? req_size       : size_q;
   assign al_off   = is_idle ? req_addr[1:0]  : off_q;
   assign al_rword = is_idle ? mmio_word      : mem.mem_resp_data;

   mem_lane_align u_align (
      .size_i  (al_size),
      .off_i   (al_off),
      .wdata_i (req_wdata),
      .rword_i (al_rword),
      .mask_o  (al_mask),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (mem_start) state_d = StReq;
         StReq:   if (mem.mem_req_ready) state_d = we_q ? StDone : StResp;
         StResp:  if (mem.mem_resp_valid) state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         size_q        <= '0;
         off_q         <= '0;
         we_q          <= 1'b0;
         mask_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         misalign_q    <= 1'b0;
         cycle_q       <= '0;
         instret_q     <= '0;
      end else begin
         state_q       <= state_d;
         rdata_valid_q <= 1'b0;
         misalign_q    <= is_idle & req_valid & live_mis;
         // A clear wins over the same cycle's increment
         cycle_q       <= clr ? 32'b0 : cycle_q + 32'd1;
         instret_q     <= clr ? 32'b0 : instret_q + {31'b0, retire};
         if (mem_start) begin
            addr_q  <= req_addr[ADDR_W+1:2];
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            we_q    <= req_we;
            mask_q  <= req_we ? al_mask : 4'b0000;
            wdata_q <= al_wdata;
         end
         if (mmio_acc & ~req_we) begin
            rdata_q       <= al_rdata;
            rdata_valid_q <= 1'b1;
         end
         if ((state_q == StResp) & mem.mem_resp_valid) begin
            rdata_q       <= al_rdata;
            rdata_valid_q <= 1'b1;
         end
      end
   end

   // Gated by reset so an aborted access releases the pipeline immediately
   assign stall = ~reset & (mem_start | (state_q == StReq) | (state_q == StResp));

   assign mem.mem_req_valid = (state_q == StReq);
   assign mem.mem_we_mask   = mask_q;
   assign mem.mem_addr      = addr_q;
   assign mem.mem_wdata     = wdata_q;

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign misalign    = misalign_q;

endmodule

// File: tb/tb_dmem_port.sv
module tb_dmem_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        retire = 1'b0;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        misalign;

   int vectors = 0;
   int fails = 0;

   dmem_port_if #(.ADDR_W(14)) mem_if ();

   dmem_port #(
      .ADDR_W   (14),
      .MMIO_TAG (4'h8)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .retire      (retire),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .misalign    (misalign),
      .mem         (mem_if)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   // Memory load with a given number of RESP wait cycles before the response
   task automatic mem_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] word, input int waits,
                           input logic [31:0] exp);
      mem_if.mem_req_ready  = 1'b1;
      mem_if.mem_resp_valid = 1'b0;
      req(1'b0, size, addr, 32'h0);
      #1 check({tag, "_idle_stall"}, stall, 1);
      cyc();
      check({tag, "_req_valid"}, mem_if.mem_req_valid, 1);
      check({tag, "_req_mask"}, mem_if.mem_we_mask, 0);
      check({tag, "_req_addr"}, mem_if.mem_addr, {16'b0, 2'b0, addr[15:2]});
      cyc();
      for (int i = 0; i < waits; i++) begin
         check({tag, "_resp_stall"}, stall, 1);
         cyc();
      end
      mem_if.mem_resp_valid = 1'b1;
      mem_if.mem_resp_data  = word;
      cyc();
      mem_if.mem_resp_valid = 1'b0;
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rvalid"}, rdata_valid, 1);
      check({tag, "_done_stall"}, stall, 0);
      req_valid = 1'b0;
      cyc();
      check({tag, "_rvalid_pulse"}, rdata_valid, 0);
   endtask

   // Single-cycle MMIO load; result appears the following cycle
   task automatic mmio_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] exp);
      req(1'b0, size, addr, 32'h0);
      #1 check({tag, "_stall"}, stall, 0);
      cyc();
      req_valid = 1'b0;
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rvalid"}, rdata_valid, 1);
   endtask

   initial begin
      mem_if.mem_req_ready  = 1'b0;
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_resp_data  = 32'h0;

      // Reset state
      #1;
      check("rst_stall", stall, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rvalid", rdata_valid, 0);
      check("rst_misalign", misalign, 0);
      check("rst_mreq", mem_if.mem_req_valid, 0);
      check("rst_mask", mem_if.mem_we_mask, 0);
      check("rst_maddr", mem_if.mem_addr, 0);
      check("rst_mwdata", mem_if.mem_wdata, 0);
      cyc();
      cyc();
      reset = 1'b0;

      // MMIO counters: 100 edges after release, retire high throughout
      retire = 1'b1;
      repeat (100) cyc();
      mmio_load("mmio_cycle100", 3'b010, 32'h8000_0010, 32'd100);
      // instret is 101 here; clear must win over this cycle's retire
      req(1'b1, 3'b010, 32'h8000_0018, 32'h0);
      #1 check("mmio_clr_stall", stall, 0);
      cyc();
      retire = 1'b0;
      mmio_load("mmio_instret_clr", 3'b010, 32'h8000_0014, 32'd0);
      retire = 1'b1;
      repeat (5) cyc();
      retire = 1'b0;
      mmio_load("mmio_instret5", 3'b010, 32'h8000_0014, 32'd5);
      mmio_load("mmio_cycle7", 3'b010, 32'h8000_0010, 32'd7);
      mmio_load("mmio_other", 3'b010, 32'h8000_0020, 32'd0);
      mmio_load("mmio_lbu", 3'b100, 32'h8000_0010, 32'd9);

      // SB to 0x103: lane 3
      mem_if.mem_req_ready = 1'b1;
      req(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
      #1 check("sb_idle_stall", stall, 1);
      cyc();
      check("sb_req_valid", mem_if.mem_req_valid, 1);
      check("sb_addr", mem_if.mem_addr, 32'h40);
      check("sb_mask", mem_if.mem_we_mask, 32'b1000);
      check("sb_wdata", mem_if.mem_wdata, 32'hABAB_ABAB);
      check("sb_req_stall", stall, 1);
      cyc();
      check("sb_done_stall", stall, 0);
      check("sb_done_mreq", mem_if.mem_req_valid, 0);
      check("sb_done_rvalid", rdata_valid, 0);
      req_valid = 1'b0;
      cyc();
      check("sb_after_rvalid", rdata_valid, 0);

      // Loads from word 0x80FF7F11
      mem_load("lb", 3'b000, 32'h0000_0102, 32'h80FF_7F11, 3, 32'hFFFF_FFFF);
      mem_load("lbu", 3'b100, 32'h0000_0102, 32'h80FF_7F11, 0, 32'h0000_00FF);
      mem_load("lh", 3'b001, 32'h0000_0102, 32'h80FF_7F11, 1, 32'hFFFF_80FF);
      mem_load("lhu", 3'b101, 32'h0000_0100, 32'h80FF_7F11, 0, 32'h0000_7F11);
      mem_load("lw", 3'b010, 32'h0000_0100, 32'h80FF_7F11, 0, 32'h80FF_7F11);

      // Misaligned requests
      req(1'b0, 3'b010, 32'h0000_0006, 32'h0);
      #1 check("mis_lw_stall", stall, 0);
      cyc();
      req_valid = 1'b0;
      check("mis_lw_pulse", misalign, 1);
      check("mis_lw_mreq", mem_if.mem_req_valid, 0);
      check("mis_lw_rvalid", rdata_valid, 0);
      cyc();
      check("mis_lw_pulse_end", misalign, 0);
      check("mis_lw_mreq2", mem_if.mem_req_valid, 0);
      req(1'b1, 3'b001, 32'h0000_0101, 32'h0);
      #1 check("mis_sh_stall", stall, 0);
      cyc();
      req_valid = 1'b0;
      check("mis_sh_pulse", misalign, 1);
      check("mis_sh_mreq", mem_if.mem_req_valid, 0);

      // SH with ready held low: request must stay stable
      mem_if.mem_req_ready = 1'b0;
      req(1'b1, 3'b001, 32'h0000_0212, 32'h0000_1234);
      cyc();
      for (int i = 0; i < 10; i++) begin
         check("hold_mreq", mem_if.mem_req_valid, 1);
         check("hold_addr", mem_if.mem_addr, 32'h84);
         check("hold_mask", mem_if.mem_we_mask, 32'b1100);
         check("hold_wdata", mem_if.mem_wdata, 32'h1234_1234);
         check("hold_stall", stall, 1);
         cyc();
      end
      mem_if.mem_req_ready = 1'b1;
      cyc();
      check("hold_done_stall", stall, 0);
      req_valid = 1'b0;
      cyc();

      // Reset while in REQ
      mem_if.mem_req_ready = 1'b0;
      req(1'b0, 3'b010, 32'h0000_0210, 32'h0);
      cyc();
      check("rstreq_pre_mreq", mem_if.mem_req_valid, 1);
      reset = 1'b1;
      #1;
      check("rstreq_mreq", mem_if.mem_req_valid, 0);
      check("rstreq_stall", stall, 0);
      req_valid = 1'b0;
      cyc();
      reset = 1'b0;

      // Reset while in RESP
      mem_if.mem_req_ready = 1'b1;
      req(1'b0, 3'b010, 32'h0000_0210, 32'h0);
      cyc();
      cyc();
      check("rstresp_pre_stall", stall, 1);
      reset = 1'b1;
      #1;
      check("rstresp_stall", stall, 0);
      check("rstresp_mreq", mem_if.mem_req_valid, 0);
      req_valid = 1'b0;
      cyc();
      reset = 1'b0;
      mmio_load("rst_cycle0", 3'b010, 32'h8000_0010, 32'd0);
      mmio_load("rst_instret0", 3'b010, 32'h8000_0014, 32'd0);

      // Counter wrap
      force u_dut.cycle_q = 32'hFFFF_FFFF;
      #1;
      release u_dut.cycle_q;
      mmio_load("wrap_max", 3'b010, 32'h8000_0010, 32'hFFFF_FFFF);
      mmio_load("wrap_zero", 3'b010, 32'h8000_0010, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
